// File: rtl/seven_segment_to_binary.sv
// Seven-segment bus monitor: synchronises and debounces the segment lines,
// then decodes each stable pattern back to its hex digit, blank or illegal.
module seven_segment_to_binary #(
  parameter int unsigned STABLE_COUNT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Binary_Num,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Error,
  output logic [6:0] o_Pattern
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NUM_W = 4;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] STABLE_PRE = CNT_W'(STABLE_COUNT - 1);

  logic [SEG_W-1:0] seg_raw;
  logic [SEG_W-1:0] s1_q, s2_q;
  logic [SEG_W-1:0] cand_q, cand_d;
  logic [SEG_W-1:0] last_q, last_d;
  logic [SEG_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             valid_q, valid_d;
  logic             blank_q, blank_d;
  logic             error_q, error_d;

  logic [NUM_W-1:0] digit_c;
  logic             legal_c;
  logic             commit_c;

  assign seg_raw = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                    i_Segment_E, i_Segment_F, i_Segment_G};

  // Decode the candidate pattern; legal_c is low for blank and illegal codes.
  always_comb begin
    digit_c = '0;
    legal_c = 1'b1;
    case (cand_q)
      7'h7E: digit_c = 4'h0;
      7'h30: digit_c = 4'h1;
      7'h6D: digit_c = 4'h2;
      7'h79: digit_c = 4'h3;
      7'h33: digit_c = 4'h4;
      7'h5B: digit_c = 4'h5;
      7'h5F: digit_c = 4'h6;
      7'h70: digit_c = 4'h7;
      7'h7F: digit_c = 4'h8;
      7'h7B: digit_c = 4'h9;
      7'h77: digit_c = 4'hA;
      7'h1F: digit_c = 4'hB;
      7'h4E: digit_c = 4'hC;
      7'h3D: digit_c = 4'hD;
      7'h4F: digit_c = 4'hE;
      7'h47: digit_c = 4'hF;
      default: legal_c = 1'b0;
    endcase
  end

  // Stability tracker and commit logic; commit only on the final count step.
  always_comb begin
    cand_d   = cand_q;
    count_d  = count_q;
    last_d   = last_q;
    pat_d    = pat_q;
    num_d    = num_q;
    valid_d  = 1'b0;
    blank_d  = blank_q;
    error_d  = error_q;
    commit_c = (s2_q == cand_q) && (count_q == STABLE_PRE) && (cand_q != last_q);

    if (s2_q != cand_q) begin
      cand_d  = s2_q;
      count_d = CNT_W'(1);
    end else if (count_q < STABLE_MAX) begin
      count_d = count_q + CNT_W'(1);
    end

    if (commit_c) begin
      last_d = cand_q;
      pat_d  = cand_q;
      if (legal_c) begin
        num_d   = digit_c;
        valid_d = 1'b1;
        blank_d = 1'b0;
        error_d = 1'b0;
      end else if (cand_q == '0) begin
        blank_d = 1'b1;
        error_d = 1'b0;
      end else begin
        blank_d = 1'b0;
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
      pat_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      blank_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      s1_q    <= seg_raw;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      count_q <= count_d;
      last_q  <= last_d;
      pat_q   <= pat_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      error_q <= error_d;
    end
  end

  assign o_Binary_Num = num_q;
  assign o_Valid      = valid_q;
  assign o_Blank      = blank_q;
  assign o_Error      = error_q;
  assign o_Pattern    = pat_q;

endmodule
